// File: rtl/serial_add3.sv
// Bit-serial adder that adds one 3-bit slice per cycle, least significant slice first.
// Defining SERIAL_ADD3_CIN_EN adds the ci port; otherwise the initial carry is 0.
module serial_add3 #(
  parameter int NCHUNK = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [3*NCHUNK-1:0] a,
  input  logic [3*NCHUNK-1:0] b,
`ifdef SERIAL_ADD3_CIN_EN
  input  logic                ci,
`endif
  output logic                busy,
  output logic                done,
  output logic [3*NCHUNK-1:0] s,
  output logic                c
);

  localparam int W  = 3 * NCHUNK;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    opA_q, opA_d;
  logic [W-1:0]    opB_q, opB_d;
  logic [W-1:0]    sum_q, sum_d;
  logic [W-1:0]    s_q, s_d;
  logic            carry_q, carry_d;
  logic            c_q, c_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            cinInit;
  logic            lastSlice;
  logic [3:0]      sliceRes;
  logic [W-1:0]    sumShift;

`ifdef SERIAL_ADD3_CIN_EN
  assign cinInit = ci;
`else
  assign cinInit = 1'b0;
`endif

  assign lastSlice = (cnt_q == CW'(NCHUNK - 1));
  assign sliceRes  = {1'b0, opA_q[2:0]} + {1'b0, opB_q[2:0]} + {3'b000, carry_q};
  // New slice enters at the top so that after NCHUNK shifts the first slice lands at bit 0.
  assign sumShift  = W'({sliceRes[2:0], sum_q} >> 3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (lastSlice) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN) || (state_q == DONE);
    done = (state_q == DONE);
  end

  always_comb begin
    opA_d   = opA_q;
    opB_d   = opB_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    c_d     = c_q;
    if ((state_q == IDLE) && start) begin
      opA_d   = a;
      opB_d   = b;
      carry_d = cinInit;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      opA_d   = opA_q >> 3;
      opB_d   = opB_q >> 3;
      sum_d   = sumShift;
      carry_d = sliceRes[3];
      cnt_d   = cnt_q + CW'(1);
      if (lastSlice) begin
        s_d = sumShift;
        c_d = sliceRes[3];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opA_q   <= '0;
      opB_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
    end else begin
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      c_q     <= c_d;
    end
  end

  assign s = s_q;
  assign c = c_q;

endmodule

// File: tb/tb_serial_add3.sv
// Directed bench for serial_add3: a 4-slice instance for most scenarios plus a 1-slice instance.
module tb_serial_add3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start0 = 1'b0;
  logic [11:0] a0 = '0;
  logic [11:0] b0 = '0;
  logic        busy0, done0;
  logic [11:0] s0;
  logic        c0;

  logic        start1 = 1'b0;
  logic [2:0]  a1 = '0;
  logic [2:0]  b1 = '0;
  logic        busy1, done1;
  logic [2:0]  s1;
  logic        c1;

`ifdef SERIAL_ADD3_CIN_EN
  logic        ci0 = 1'b0;
  logic        ci1 = 1'b0;
`endif

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  serial_add3 #(.NCHUNK(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0),
`ifdef SERIAL_ADD3_CIN_EN
    .ci(ci0),
`endif
    .busy(busy0), .done(done0), .s(s0), .c(c0)
  );

  serial_add3 #(.NCHUNK(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
`ifdef SERIAL_ADD3_CIN_EN
    .ci(ci1),
`endif
    .busy(busy1), .done(done1), .s(s1), .c(c1)
  );

  // Asynchronous reset values, then release so the next start hits the first edge after release
  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    testsRun++;
    if ({busy0, done0, s0, c0} !== 14'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset4: got busy=%b done=%b s=%h c=%b expected all zero", busy0, done0, s0, c0);
    end
    testsRun++;
    if ({busy1, done1, s1, c1} !== 6'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset1: got busy=%b done=%b s=%h c=%b expected all zero", busy1, done1, s1, c1);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One operation on the 4-slice DUT; operands are scrambled right after acceptance
  task automatic runOp(input string name, input logic [11:0] av, input logic [11:0] bv,
                       input logic [11:0] expS, input logic expC);
    int doneCount = 0;
    int doneCycle = 0;
    logic [11:0] gotS = '0;
    logic gotC = 1'b0;
    start0 = 1'b1;
    a0 = av;
    b0 = bv;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done0) begin
        doneCount++;
        if (doneCount == 1) begin
          doneCycle = k;
          gotS = s0;
          gotC = c0;
        end
      end
      if (k == 1) begin
        testsRun++;
        if (busy0 !== 1'b1) begin
          testsFailed++;
          $display("[TB] FAIL %s busy: got %b expected 1", name, busy0);
        end
        start0 = 1'b0;
        a0 = ~av;
        b0 = ~bv;
      end
      if (k == 6) begin
        testsRun++;
        if (busy0 !== 1'b0) begin
          testsFailed++;
          $display("[TB] FAIL %s idle: got busy=%b expected 0", name, busy0);
        end
      end
    end
    testsRun++;
    if (doneCount !== 1 || doneCycle !== 5) begin
      testsFailed++;
      $display("[TB] FAIL %s done: got %0d pulses first at cycle %0d expected 1 at cycle 5",
               name, doneCount, doneCycle);
    end
    testsRun++;
    if ({gotC, gotS} !== {expC, expS}) begin
      testsFailed++;
      $display("[TB] FAIL %s result: got c=%b s=%h expected c=%b s=%h", name, gotC, gotS, expC, expS);
    end
  endtask

  task automatic test_patterns;
`ifdef SERIAL_ADD3_CIN_EN
    ci0 = 1'b0;
`endif
    runOp("wrap",  12'hFFF, 12'h001, 12'h000, 1'b1);
    runOp("alt",   12'h5A5, 12'h25A, 12'h7FF, 1'b0);
`ifdef SERIAL_ADD3_CIN_EN
    ci0 = 1'b1;
    runOp("cin",   12'h7FF, 12'h000, 12'h800, 1'b0);
    ci0 = 1'b0;
`else
    runOp("ripple", 12'h7FF, 12'h001, 12'h800, 1'b0);
`endif
    runOp("topc",  12'h800, 12'h800, 12'h000, 1'b1);
    runOp("mixed", 12'hABC, 12'h123, 12'hBDF, 1'b0);
  endtask

  // Extra start pulses in RUN and DONE must not disturb the operation in flight
  task automatic test_ignore_start;
    int doneCount = 0;
    int doneCycle = 0;
    logic [11:0] gotS = '0;
    logic holdOk = 1'b1;
    start0 = 1'b1;
    a0 = 12'h001;
    b0 = 12'h001;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (done0) begin
        doneCount++;
        if (doneCount == 1) begin
          doneCycle = k;
          gotS = s0;
        end
      end
      if (k < 5 && s0 !== 12'hBDF) holdOk = 1'b0;
      start0 = (k == 2) || (k == 5);
    end
    testsRun++;
    if (!holdOk) begin
      testsFailed++;
      $display("[TB] FAIL ignore hold: s changed before done, expected %h held", 12'hBDF);
    end
    testsRun++;
    if (doneCount !== 1 || doneCycle !== 5) begin
      testsFailed++;
      $display("[TB] FAIL ignore done: got %0d pulses first at cycle %0d expected 1 at cycle 5",
               doneCount, doneCycle);
    end
    testsRun++;
    if (gotS !== 12'h002) begin
      testsFailed++;
      $display("[TB] FAIL ignore result: got s=%h expected 002", gotS);
    end
  endtask

  // Reset in the middle of RUN clears everything at once and yields no done
  task automatic test_reset_mid_run;
    logic quietOk = 1'b1;
    runOp("prior", 12'h800, 12'h900, 12'h100, 1'b1);
    start0 = 1'b1;
    a0 = 12'h111;
    b0 = 12'h222;
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    testsRun++;
    if ({busy0, done0, s0, c0} !== 14'h0) begin
      testsFailed++;
      $display("[TB] FAIL midreset: got busy=%b done=%b s=%h c=%b expected all zero",
               busy0, done0, s0, c0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done0 || busy0) quietOk = 1'b0;
    end
    testsRun++;
    if (!quietOk) begin
      testsFailed++;
      $display("[TB] FAIL midreset quiet: got done/busy activity expected none");
    end
  endtask

  task automatic test_nchunk1;
    int doneCycle = 0;
    logic [2:0] gotS = '0;
    logic gotC = 1'b0;
    logic [2:0] expS;
    start1 = 1'b1;
    a1 = 3'd7;
    b1 = 3'd7;
`ifdef SERIAL_ADD3_CIN_EN
    ci1 = 1'b1;
    expS = 3'd7;
`else
    expS = 3'd6;
`endif
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (done1 && doneCycle == 0) begin
        doneCycle = k;
        gotS = s1;
        gotC = c1;
      end
      start1 = 1'b0;
    end
    testsRun++;
    if (doneCycle !== 2) begin
      testsFailed++;
      $display("[TB] FAIL n1 done: got cycle %0d expected 2", doneCycle);
    end
    testsRun++;
    if ({gotC, gotS} !== {1'b1, expS}) begin
      testsFailed++;
      $display("[TB] FAIL n1 result: got c=%b s=%h expected c=1 s=%h", gotC, gotS, expS);
    end
  endtask

  // start held high: new operation begins in the IDLE cycle after each DONE
  task automatic test_back_to_back;
    logic [11:0] pa [3];
    logic [11:0] pb [3];
    logic [11:0] es [3];
    logic        ec [3];
    int          expCyc [3];
    int          dc = 0;
    int          idx;
    pa = '{12'h123, 12'hFFF, 12'h700};
    pb = '{12'h456, 12'hFFF, 12'h100};
`ifdef SERIAL_ADD3_CIN_EN
    es = '{12'h579, 12'hFFF, 12'h800};
`else
    es = '{12'h579, 12'hFFE, 12'h800};
`endif
    ec = '{1'b0, 1'b1, 1'b0};
    expCyc = '{5, 11, 17};
    start0 = 1'b1;
    a0 = pa[0];
    b0 = pb[0];
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (done0) begin
        if (dc < 3) begin
          testsRun++;
          if (k !== expCyc[dc] || s0 !== es[dc] || c0 !== ec[dc]) begin
            testsFailed++;
            $display("[TB] FAIL b2b op%0d: got cycle %0d c=%b s=%h expected cycle %0d c=%b s=%h",
                     dc, k, c0, s0, expCyc[dc], ec[dc], es[dc]);
          end
        end
        dc++;
      end
      if (k >= 17) start0 = 1'b0;
      idx = (k / 6 > 2) ? 2 : k / 6;
      a0 = pa[idx];
      b0 = pb[idx];
`ifdef SERIAL_ADD3_CIN_EN
      ci0 = (idx == 1);
`endif
    end
    testsRun++;
    if (dc !== 3) begin
      testsFailed++;
      $display("[TB] FAIL b2b count: got %0d done pulses expected 3", dc);
    end
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_ignore_start();
    test_reset_mid_run();
    test_nchunk1();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/serial_add3.md
SERIAL_ADD3 -- requirements
Module: serial_add3

Interface
REQ-001 SHALL provide parameter NCHUNK, default 4, number of 3-bit slices per operand (legal 1..16; operand width W = 3*NCHUNK).
REQ-002 SHALL provide port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL provide port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL provide port start, input, 1, request to add a and b; sampled only in IDLE.
REQ-005 SHALL provide port a, input, W, operand A, captured on accepted start.
REQ-006 SHALL provide port b, input, W, operand B, captured on accepted start.
REQ-007 SHALL provide port ci, input, 1, initial carry-in, captured on accepted start (present only per REQ-027).
REQ-008 SHALL provide port busy, output, 1, high while an addition is in progress (RUN and DONE states).
REQ-009 SHALL provide port done, output, 1, single-cycle pulse marking a valid result.
REQ-010 SHALL provide port s, output, W, registered sum.
REQ-011 SHALL provide port c, output, 1, registered carry-out of the top slice.

Function
REQ-012 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE when slice counter reaches NCHUNK-1, DONE->IDLE unconditionally after one cycle.
REQ-013 On accepted start SHALL load internal operand shift registers with a, b, carry register with ci, slice counter with 0.
REQ-014 In RUN, each cycle SHALL add the low 3 bits of each operand register plus carry register (3-bit full-adder slice), shift the 3-bit slice sum into the top of the internal sum register, shift both operand registers right by 3, store slice carry-out in carry register, increment counter.
REQ-015 Exactly one slice SHALL be processed per RUN cycle; slices processed LSB-first.
REQ-016 On RUN->DONE transition SHALL copy the completed internal sum to s and final carry to c.
REQ-017 done SHALL be high for exactly the one cycle in DONE; start accepted in cycle 0 yields done high in cycle NCHUNK+1.
REQ-018 s and c SHALL hold their last result from DONE until the next DONE, including throughout the following operation.
REQ-019 start while busy is high (RUN or DONE) SHALL be ignored with no effect on the running operation.
REQ-020 start held high continuously SHALL start a new operation in the first IDLE cycle after each DONE (back-to-back period NCHUNK+2 cycles).
REQ-021 a and b changing after the start cycle SHALL not affect the result.
REQ-022 Result SHALL equal (a + b + ci) mod 2^W in s with bit W in c; no overflow or wrap other than this.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, busy=0, done=0, s=0, c=0, counter=0, carry and operand registers 0.
REQ-024 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL be produced for it.
REQ-025 After rst_n deasserts, first start SHALL be accepted on the first rising edge with rst_n high.

Configuration
REQ-026 Macro SERIAL_ADD3_CIN_EN SHALL control the carry-in feature.
REQ-027 With SERIAL_ADD3_CIN_EN defined, port ci SHALL exist and be captured per REQ-013; without it, port ci SHALL be absent and initial carry SHALL be 0.

Verification
REQ-028 NCHUNK=4, a=0xFFF, b=0x001, ci=0, start cycle 0 -> done cycle 5, s=0x000, c=1.
REQ-029 NCHUNK=4, a=0x5A5, b=0x25A, ci=0 -> s=0x7FF, c=0; with SERIAL_ADD3_CIN_EN, a=0x7FF, b=0x000, ci=1 -> s=0x800, c=0.
REQ-030 start pulsed again in cycles 2 and 5 of an operation (a=0x001,b=0x001) -> ignored; single done in cycle 5 with the first result; s unchanged until that done.
REQ-031 rst_n low during RUN cycle 2 -> busy=0, done=0, s=0, c=0 immediately; no later done without new start.
REQ-032 NCHUNK=1, a=7, b=7, ci=1 (macro defined) -> done cycle 2, s=7, c=1; macro undefined -> s=6, c=1.
REQ-033 start held high, three sequential operand pairs -> done pulses at cycles 5, 11, 17, each result matching REQ-022.
